// File: rtl/mbinit_pkg.sv
`default_nettype none
// ============================================================================
// mbinit_pkg : shared MBINIT types, sideband message codes and helpers
// Rev 1.0
// ============================================================================
package mbinit_pkg;

    localparam int MSG_W_DEF  = 4;
    localparam int INFO_W_DEF = 3;

    localparam logic [3:0] SB_MSG_NONE                 = 4'h0;
    localparam logic [3:0] SB_MSG_REPAIRCLK_INIT_REQ   = 4'h1;
    localparam logic [3:0] SB_MSG_REPAIRCLK_INIT_RESP  = 4'h2;
    localparam logic [3:0] SB_MSG_REPAIRCLK_RESULT_REQ = 4'h3;
    localparam logic [3:0] SB_MSG_REPAIRCLK_RESULT_RSP = 4'h4;
    localparam logic [3:0] SB_MSG_REPAIRCLK_DONE_REQ   = 4'h5;
    localparam logic [3:0] SB_MSG_REPAIRCLK_DONE_RESP  = 4'h6;
    localparam logic [3:0] SB_MSG_REPAIRVAL_INIT_REQ   = 4'h7;
    localparam logic [3:0] SB_MSG_REPAIRVAL_INIT_RESP  = 4'h8;
    localparam logic [3:0] SB_MSG_REPAIRVAL_RESULT_REQ = 4'h9;
    localparam logic [3:0] SB_MSG_REPAIRVAL_RESULT_RSP = 4'hA;
    localparam logic [3:0] SB_MSG_REPAIRVAL_DONE_REQ   = 4'hB;
    localparam logic [3:0] SB_MSG_REPAIRVAL_DONE_RESP  = 4'hC;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_GAP  = 2'd3
    } arb_state_t;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mbinit_pkg
`default_nettype wire

// File: rtl/ltsm_rr_pick.sv
`default_nettype none
// ============================================================================
// ltsm_rr_pick : combinational round-robin pick (first set bit at/after ptr)
// Rev 1.0
// ============================================================================
module ltsm_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin : p_pick
        int k;
        k     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end

endmodule : ltsm_rr_pick
`default_nettype wire

// File: rtl/mbinit_sb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// mbinit_sb_tx_arbiter : round-robin owner of the MBINIT sideband TX port
// Rev 1.0
// ============================================================================
module mbinit_sb_tx_arbiter
    import mbinit_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MSG_W       = MSG_W_DEF,
    parameter int INFO_W      = INFO_W_DEF,
    parameter int TIMEOUT_CYC = 8000
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      i_enable,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*MSG_W-1:0]  i_req_msg,
    input  logic [NUM_REQ*INFO_W-1:0] i_req_info,
    input  logic                      i_falling_edge_busy,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [NUM_REQ-1:0]        o_done,
    output logic [MSG_W-1:0]          o_TX_SbMessage,
    output logic [INFO_W-1:0]         o_TX_info,
    output logic                      o_ValidOutData,
    output logic                      o_timeout_err
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC);

    arb_state_t          state, state_nxt;
    logic [NUM_REQ-1:0]  grant_q, grant_nxt;
    logic [NUM_REQ-1:0]  done_q, done_nxt;
    logic [MSG_W-1:0]    msg_q, msg_nxt;
    logic [INFO_W-1:0]   info_q, info_nxt;
    logic                valid_q, valid_nxt;
    logic                err_q, err_nxt;
    logic [IDX_W-1:0]    ptr_q, ptr_nxt;
    logic [IDX_W-1:0]    owner_q, owner_nxt;
    logic [TMR_W-1:0]    timer_q, timer_nxt;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    ltsm_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (i_req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            msg_q   <= '0;
            info_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
            timer_q <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            done_q  <= done_nxt;
            msg_q   <= msg_nxt;
            info_q  <= info_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
            ptr_q   <= ptr_nxt;
            owner_q <= owner_nxt;
            timer_q <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        done_nxt  = '0;
        msg_nxt   = msg_q;
        info_nxt  = info_q;
        valid_nxt = 1'b0;
        err_nxt   = err_q;
        ptr_nxt   = ptr_q;
        owner_nxt = owner_q;
        timer_nxt = timer_q;

        if (!i_enable) begin
            // Substate left: drop everything, in-flight message is never acked.
            state_nxt = ARB_IDLE;
            grant_nxt = '0;
            msg_nxt   = '0;
            info_nxt  = '0;
            err_nxt   = 1'b0;
            ptr_nxt   = '0;
            owner_nxt = '0;
            timer_nxt = '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    grant_nxt = '0;
                    if (pick_any && !err_q) begin
                        grant_nxt = pick_grant;
                        owner_nxt = pick_idx;
                        msg_nxt   = i_req_msg[pick_idx*MSG_W +: MSG_W];
                        info_nxt  = i_req_info[pick_idx*INFO_W +: INFO_W];
                        state_nxt = ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    valid_nxt = 1'b1;
                    timer_nxt = '0;
                    state_nxt = ARB_WAIT;
                end
                ARB_WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (i_falling_edge_busy) begin
                        done_nxt  = grant_q;
                        grant_nxt = '0;
                        ptr_nxt   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                        state_nxt = ARB_GAP;
                    end else if (timer_q == TMR_LAST) begin
                        err_nxt   = 1'b1;
                        grant_nxt = '0;
                        state_nxt = ARB_IDLE;
                    end else if (timer_q != TMR_MAX) begin
                        timer_nxt = timer_q + 1'b1;
                    end
                end
                ARB_GAP: begin
                    state_nxt = ARB_IDLE;
                end
                default: begin
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                end
            endcase
        end
    end

    assign o_grant        = grant_q;
    assign o_done         = done_q;
    assign o_TX_SbMessage = msg_q;
    assign o_TX_info      = info_q;
    assign o_ValidOutData = valid_q;
    assign o_timeout_err  = err_q;

endmodule : mbinit_sb_tx_arbiter
`default_nettype wire

// File: tb/tb_mbinit_sb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mbinit_sb_tx_arbiter : table-driven + scoreboard bench for the TX arbiter
// Rev 1.0
// ============================================================================
module tb_mbinit_sb_tx_arbiter;

    localparam int NR = 4;
    localparam int MW = 4;
    localparam int IW = 3;
    localparam int TC = 16;

    localparam logic [NR*MW-1:0] STD_M = 16'hDCBA;
    localparam logic [NR*IW-1:0] STD_I = {3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [NR*MW-1:0] ONE_M = 16'h0005;
    localparam logic [NR*IW-1:0] ONE_I = {3'd0, 3'd0, 3'd0, 3'b101};

    logic                CLK;
    logic                rst_n;
    logic                i_enable;
    logic [NR-1:0]       i_req;
    logic [NR*MW-1:0]    i_req_msg;
    logic [NR*IW-1:0]    i_req_info;
    logic                i_falling_edge_busy;
    logic [NR-1:0]       o_grant;
    logic [NR-1:0]       o_done;
    logic [MW-1:0]       o_TX_SbMessage;
    logic [IW-1:0]       o_TX_info;
    logic                o_ValidOutData;
    logic                o_timeout_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*MW-1:0] msgv;
        logic [NR*IW-1:0] infov;
        logic [NR-1:0]    exp_grant;
        logic [MW-1:0]    exp_msg;
        logic [IW-1:0]    exp_info;
        int               dly;
        bit               drop;
    } vec_t;

    typedef struct {
        logic [NR-1:0] g;
        logic [MW-1:0] m;
        logic [IW-1:0] i;
    } sb_t;

    vec_t tbl[10];
    sb_t  sbq[$];

    mbinit_sb_tx_arbiter #(
        .NUM_REQ     (NR),
        .MSG_W       (MW),
        .INFO_W      (IW),
        .TIMEOUT_CYC (TC)
    ) dut (
        .CLK                 (CLK),
        .rst_n               (rst_n),
        .i_enable            (i_enable),
        .i_req               (i_req),
        .i_req_msg           (i_req_msg),
        .i_req_info          (i_req_info),
        .i_falling_edge_busy (i_falling_edge_busy),
        .o_grant             (o_grant),
        .o_done              (o_done),
        .o_TX_SbMessage      (o_TX_SbMessage),
        .o_TX_info           (o_TX_info),
        .o_ValidOutData      (o_ValidOutData),
        .o_timeout_err       (o_timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_ValidOutData && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    // Scoreboard consumer: every send strobe must match the oldest expectation.
    always @(negedge CLK) begin
        if (rst_n && o_ValidOutData) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 32'(o_ValidOutData), 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                check("sb_grant", 32'(o_grant), 32'(e.g));
                check("sb_msg", 32'(o_TX_SbMessage), 32'(e.m));
                check("sb_info", 32'(o_TX_info), 32'(e.i));
            end
        end
    end

    task automatic run_row(input vec_t v);
        int lat;
        i_req      = v.req;
        i_req_msg  = v.msgv;
        i_req_info = v.infov;
        sbq.push_back('{v.exp_grant, v.exp_msg, v.exp_info});
        wait_valid(lat);
        check("latency", 32'(lat), 32'd2);
        if (v.drop) i_req = '0;
        repeat (v.dly) tick();
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        check("done", 32'(o_done), 32'(v.exp_grant));
        check("grant_clr", 32'(o_grant), 32'd0);
        check("valid_once", 32'(o_ValidOutData), 32'd0);
        tick();
        check("done_1cyc", 32'(o_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int  lat;
        bit  seen;

        tbl[0] = '{4'b1111, STD_M, STD_I, 4'b0001, 4'hA, 3'd1, 3, 1'b0};
        tbl[1] = '{4'b1111, STD_M, STD_I, 4'b0010, 4'hB, 3'd2, 3, 1'b0};
        tbl[2] = '{4'b1111, STD_M, STD_I, 4'b0100, 4'hC, 3'd3, 3, 1'b0};
        tbl[3] = '{4'b1111, STD_M, STD_I, 4'b1000, 4'hD, 3'd4, 3, 1'b0};
        tbl[4] = '{4'b1111, STD_M, STD_I, 4'b0001, 4'hA, 3'd1, 3, 1'b0};
        tbl[5] = '{4'b0001, ONE_M, ONE_I, 4'b0001, 4'h5, 3'd5, 10, 1'b0};
        tbl[6] = '{4'b0100, STD_M, STD_I, 4'b0100, 4'hC, 3'd3, 1, 1'b0};
        tbl[7] = '{4'b0011, STD_M, STD_I, 4'b0001, 4'hA, 3'd1, 0, 1'b0};
        tbl[8] = '{4'b1010, STD_M, STD_I, 4'b0010, 4'hB, 3'd2, 2, 1'b0};
        tbl[9] = '{4'b1001, STD_M, STD_I, 4'b1000, 4'hD, 3'd4, 5, 1'b1};

        rst_n               = 1'b0;
        i_enable            = 1'b0;
        i_req               = '0;
        i_req_msg           = STD_M;
        i_req_info          = STD_I;
        i_falling_edge_busy = 1'b0;
        repeat (3) tick();
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_msg", 32'(o_TX_SbMessage), 32'd0);
        check("rst_info", 32'(o_TX_info), 32'd0);
        check("rst_valid", 32'(o_ValidOutData), 32'd0);
        check("rst_err", 32'(o_timeout_err), 32'd0);
        rst_n    = 1'b1;
        i_enable = 1'b1;
        tick();

        // Busy edge while idle must be ignored.
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        check("idle_edge_done", 32'(o_done), 32'd0);
        check("idle_edge_grant", 32'(o_grant), 32'd0);

        // Round-robin, single request, wrap and owner-drop rows; pointer ends at 0.
        for (int r = 0; r < 10; r++) begin
            run_row(tbl[r]);
        end

        // Completion on the very cycle the timer expires: completion wins.
        i_req = 4'b0100;
        sbq.push_back('{4'b0100, 4'hC, 3'd3});
        wait_valid(lat);
        check("et_latency", 32'(lat), 32'd2);
        repeat (TC - 1) tick();
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        check("et_done", 32'(o_done), 32'b0100);
        check("et_err", 32'(o_timeout_err), 32'd0);
        tick();
        check("et_err_gap", 32'(o_timeout_err), 32'd0);

        // Timeout with pointer at 3.
        i_req = 4'b1000;
        sbq.push_back('{4'b1000, 4'hD, 3'd4});
        wait_valid(lat);
        check("to_latency", 32'(lat), 32'd2);
        repeat (TC - 1) tick();
        check("to_err_early", 32'(o_timeout_err), 32'd0);
        tick();
        check("to_err", 32'(o_timeout_err), 32'd1);
        check("to_grant", 32'(o_grant), 32'd0);
        check("to_done", 32'(o_done), 32'd0);
        i_req = 4'b1111;
        seen  = 1'b0;
        repeat (5) begin
            tick();
            if (o_grant != '0 || o_ValidOutData) seen = 1'b1;
        end
        check("to_blocked", 32'(seen), 32'd0);
        check("to_err_sticky", 32'(o_timeout_err), 32'd1);
        i_enable = 1'b0;
        i_req    = '0;
        tick();
        check("en_clr_err", 32'(o_timeout_err), 32'd0);
        i_enable = 1'b1;

        // Pointer must be back at 0: 1001 picks requester 0.
        i_req = 4'b1001;
        sbq.push_back('{4'b0001, 4'hA, 3'd1});
        wait_valid(lat);
        check("ptr_clr_latency", 32'(lat), 32'd2);
        repeat (2) tick();
        i_enable = 1'b0;
        tick();
        check("drop_grant", 32'(o_grant), 32'd0);
        check("drop_done", 32'(o_done), 32'd0);
        check("drop_valid", 32'(o_ValidOutData), 32'd0);
        check("drop_msg", 32'(o_TX_SbMessage), 32'd0);
        check("drop_info", 32'(o_TX_info), 32'd0);
        check("drop_err", 32'(o_timeout_err), 32'd0);
        i_enable            = 1'b1;
        i_req               = '0;
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        check("late_edge_done", 32'(o_done), 32'd0);
        tick();
        check("late_edge_done2", 32'(o_done), 32'd0);

        // Asynchronous reset during SEND.
        i_req = 4'b0001;
        tick();
        check("send_grant", 32'(o_grant), 32'b0001);
        check("send_msg", 32'(o_TX_SbMessage), 32'hA);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant", 32'(o_grant), 32'd0);
        check("arst_msg", 32'(o_TX_SbMessage), 32'd0);
        check("arst_info", 32'(o_TX_info), 32'd0);
        @(posedge CLK);
        #1;
        i_req = '0;
        rst_n = 1'b1;
        tick();
        check("post_rst_grant", 32'(o_grant), 32'd0);
        check("post_rst_valid", 32'(o_ValidOutData), 32'd0);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mbinit_sb_tx_arbiter
`default_nettype wire
